// File: rtl/hms_feeder_pkg.sv
// hms_feeder shared types and constants.
// Way count, terminal record and per-way state.
package hms_feeder_pkg;

  localparam int E_LOG_D    = 2;
  localparam int DATW_D     = 64;
  localparam int KEYW_D     = 32;
  localparam int FIFO_LOG_D = 3;

  function automatic int way_cnt(input int e_log);
    return 1 << e_log;
  endfunction

  localparam int W_D = way_cnt(E_LOG_D);

  localparam logic [DATW_D-1:0] TERM_REC =
    {{(DATW_D-KEYW_D){1'b0}}, {KEYW_D{1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_TERM,
    ST_FIN
  } way_st_e;

endpackage

// File: rtl/hms_feeder_if.sv
// hms_feeder record stream interface.
// Loader drives master, feeder is slave.
interface hms_feeder_if
  import hms_feeder_pkg::*;
#(
  parameter int DATW  = DATW_D,
  parameter int E_LOG = E_LOG_D
);
  logic [DATW-1:0]  S_DIN;
  logic [E_LOG-1:0] S_WAY;
  logic             S_LAST;
  logic             S_VALID;
  logic             S_READY;

  modport master (
    output S_DIN, S_WAY, S_LAST, S_VALID,
    input  S_READY
  );

  modport slave (
    input  S_DIN, S_WAY, S_LAST, S_VALID,
    output S_READY
  );
endinterface

// File: rtl/hms_feeder_fifo.sv
// hms_feeder per-way synchronous FIFO.
// Head is read combinationally; clr empties it.
module hms_feeder_fifo #(
  parameter int DW  = 65,
  parameter int LOG = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int D = 1 << LOG;

  logic [DW-1:0] mem_q [D];
  logic [LOG:0]  wp_q;
  logic [LOG:0]  rp_q;

  assign rdata = mem_q[rp_q[LOG-1:0]];
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[LOG] != rp_q[LOG]) &&
                 (wp_q[LOG-1:0] == rp_q[LOG-1:0]);

  // storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
    end else if (push && !full) begin
      mem_q[wp_q[LOG-1:0]] <= wdata;
    end
  end

  // pointer update; clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (clr) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push && !full) wp_q <= wp_q + 1'b1;
      if (pop && !empty) rp_q <= rp_q + 1'b1;
    end
  end
endmodule

// File: rtl/hms_feeder.sv
// hms_feeder: per-way buffered feeder for the merge tree.
// Appends one terminal record after each way's last.
module hms_feeder
  import hms_feeder_pkg::*;
#(
  parameter int E_LOG    = E_LOG_D,
  parameter int DATW     = DATW_D,
  parameter int KEYW     = KEYW_D,
  parameter int FIFO_LOG = FIFO_LOG_D
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic [(1<<E_LOG)-1:0]    FULL,
  hms_feeder_if.slave              s,
  output logic [(DATW<<E_LOG)-1:0] DIN,
  output logic [(1<<E_LOG)-1:0]    DINEN,
  output logic                     DONE
);
  localparam int W = way_cnt(E_LOG);
  localparam logic [DATW-1:0] TERM =
    {{(DATW-KEYW){1'b0}}, {KEYW{1'b1}}};

  way_st_e              st_q [W];
  logic [W-1:0]         last_q;
  logic [W-1:0]         dinen_q;
  logic [(DATW*W)-1:0]  din_q;
  logic                 done_q;

  logic [DATW:0] rd [W];
  logic [W-1:0]  ful;
  logic [W-1:0]  emp;
  logic [W-1:0]  pop;
  logic [W-1:0]  push_w;
  logic          busy;
  logic          all_fin;
  logic          start_ok;
  logic          rdy;
  logic          acc;

  // batch status across ways
  always_comb begin
    busy    = 1'b0;
    all_fin = 1'b1;
    for (int i = 0; i < W; i++) begin
      busy    = busy | (st_q[i] == ST_RUN) |
                (st_q[i] == ST_TERM);
      all_fin = all_fin & (st_q[i] == ST_FIN);
    end
  end

  assign start_ok  = START & ~busy;
  assign rdy       = (st_q[s.S_WAY] == ST_RUN) &
                     ~ful[s.S_WAY] & ~last_q[s.S_WAY];
  assign acc       = s.S_VALID & rdy;
  assign s.S_READY = rdy;

  for (genvar g = 0; g < W; g++) begin : g_way
    assign push_w[g] = acc && (s.S_WAY == E_LOG'(g));
    assign pop[g]    = (st_q[g] == ST_RUN) &
                       ~emp[g] & ~FULL[g];

    hms_feeder_fifo #(
      .DW  (DATW + 1),
      .LOG (FIFO_LOG)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .clr   (start_ok),
      .push  (push_w[g]),
      .pop   (pop[g]),
      .wdata ({s.S_LAST, s.S_DIN}),
      .rdata (rd[g]),
      .full  (ful[g]),
      .empty (emp[g])
    );
  end

  // per-way FSM with registered lane outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < W; i++) st_q[i] <= ST_IDLE;
      last_q  <= '0;
      dinen_q <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      dinen_q <= '0;
      done_q  <= start_ok ? 1'b0 : all_fin;
      for (int i = 0; i < W; i++) begin
        if (start_ok) begin
          st_q[i]   <= ST_RUN;
          last_q[i] <= 1'b0;
        end else begin
          if (push_w[i] && s.S_LAST) last_q[i] <= 1'b1;
          if (pop[i]) begin
            dinen_q[i]              <= 1'b1;
            din_q[DATW*i +: DATW]   <= rd[i][DATW-1:0];
            if (rd[i][DATW]) begin
              st_q[i]   <= ST_TERM;
              last_q[i] <= 1'b0;
            end
          end else if (st_q[i] == ST_TERM && !FULL[i]) begin
            dinen_q[i]            <= 1'b1;
            din_q[DATW*i +: DATW] <= TERM;
            st_q[i]               <= ST_FIN;
          end
        end
      end
    end
  end

  assign DIN   = din_q;
  assign DINEN = dinen_q;
  assign DONE  = done_q;
endmodule

// File: tb/tb_hms_feeder.sv
// hms_feeder bench: scenario tasks with a
// per-lane expected/observed scoreboard.
module tb_hms_feeder;
  localparam logic [63:0] TREC = 64'h0000_0000_FFFF_FFFF;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [3:0]   FULL = 4'h0;
  logic [255:0] DIN;
  logic [3:0]   DINEN;
  logic         DONE;

  hms_feeder_if sif();

  hms_feeder dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .FULL  (FULL),
    .s     (sif),
    .DIN   (DIN),
    .DINEN (DINEN),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_en = -1;
  int done_rise = -1;
  bit done_prev = 1'b0;
  int pulses [4];
  logic [63:0] exp_q [4][$];
  logic [63:0] obs_q [4][$];

  function automatic logic [63:0] rec(input int k);
    return {32'hA500_0000 + 32'(k), 32'(k)};
  endfunction

  // advance one clock and capture lane outputs
  task automatic cycle();
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (DINEN[i]) begin
        obs_q[i].push_back(DIN[64*i +: 64]);
        pulses[i]++;
      end
    if (|DINEN) last_en = cyc;
    if (DONE && !done_prev) done_rise = cyc;
    done_prev = DONE;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  task automatic apply_reset();
    sif.S_VALID = 1'b0;
    START = 1'b0;
    FULL = 4'h0;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    clear_sb();
    done_prev = 1'b0;
    cycle();
  endtask

  task automatic pulse_start();
    START = 1'b1;
    cycle();
    START = 1'b0;
  endtask

  task automatic send(input int w, input logic [63:0] d,
                      input bit last, input int budget,
                      output bit ok);
    sif.S_DIN = d;
    sif.S_WAY = 2'(w);
    sif.S_LAST = last;
    sif.S_VALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n <= budget; n++) begin
      #1;
      if (sif.S_READY) ok = 1'b1;
      cycle();
      if (ok) break;
    end
    sif.S_VALID = 1'b0;
    if (ok) begin
      exp_q[w].push_back(d);
      if (last) exp_q[w].push_back(TREC);
    end
  endtask

  task automatic wait_out(input int budget);
    bit met;
    for (int n = 0; n < budget; n++) begin
      met = 1'b1;
      for (int i = 0; i < 4; i++)
        if (obs_q[i].size() < exp_q[i].size()) met = 1'b0;
      if (met) break;
      cycle();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    sif.S_VALID = 1'b0;
    sif.S_WAY = 2'd0;
    #2;
    n_cmp++;
    if (sif.S_READY !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready got %b want 0", sif.S_READY);
    end
    n_cmp++;
    if (DINEN !== 4'h0) begin
      n_err++;
      $display("FAIL rst_dinen got %h want 0", DINEN);
    end
    n_cmp++;
    if (DIN !== 256'h0) begin
      n_err++;
      $display("FAIL rst_din got %h want 0", DIN);
    end
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_err++;
      $display("FAIL rst_done got %b want 0", DONE);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    bit ok;
    logic [63:0] o, e;
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 3; k++) send(0, rec(k), k == 3, 4, ok);
    for (int w = 1; w < 4; w++) send(w, rec(16*w), 1'b1, 4, ok);
    wait_out(40);
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_q[i].size() != exp_q[i].size()) begin
        n_err++;
        $display("FAIL basic_cnt lane%0d got %0d want %0d",
                 i, obs_q[i].size(), exp_q[i].size());
      end
      while (obs_q[i].size() > 0 && exp_q[i].size() > 0) begin
        o = obs_q[i].pop_front();
        e = exp_q[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++;
          $display("FAIL basic_rec lane%0d got %h want %h", i, o, e);
        end
      end
    end
    n_cmp++;
    if (done_rise !== last_en + 1) begin
      n_err++;
      $display("FAIL basic_done got cyc %0d want %0d",
               done_rise, last_en + 1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc, run;
    int p0;
    logic [63:0] o, e;
    apply_reset();
    FULL = 4'b0010;
    pulse_start();
    acc = 0;
    p0 = pulses[1];
    for (int k = 0; k < 8; k++) begin
      send(1, rec(100 + k), 1'b0, 2, ok);
      if (ok) acc++;
    end
    n_cmp++;
    if (acc != 8) begin
      n_err++;
      $display("FAIL bp_accept got %0d want 8", acc);
    end
    send(1, rec(200), 1'b0, 0, ok);
    n_cmp++;
    if (ok !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_drop got %b want 0", ok);
    end
    n_cmp++;
    if (pulses[1] != p0) begin
      n_err++;
      $display("FAIL bp_hold got %0d want 0", pulses[1] - p0);
    end
    FULL = 4'h0;
    run = 0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (DINEN[1]) run++;
      else if (run > 0) break;
    end
    n_cmp++;
    if (run != 8) begin
      n_err++;
      $display("FAIL bp_run got %0d want 8", run);
    end
    n_cmp++;
    if (obs_q[1].size() != exp_q[1].size()) begin
      n_err++;
      $display("FAIL bp_cnt got %0d want %0d",
               obs_q[1].size(), exp_q[1].size());
    end
    while (obs_q[1].size() > 0 && exp_q[1].size() > 0) begin
      o = obs_q[1].pop_front();
      e = exp_q[1].pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL bp_rec got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_midstream_full();
    bit ok;
    int p0;
    logic [63:0] o, e;
    apply_reset();
    FULL = 4'b0100;
    pulse_start();
    for (int k = 0; k < 6; k++) send(2, rec(300 + k), k == 5, 2, ok);
    FULL = 4'h0;
    cycle();
    cycle();
    FULL = 4'b0100;
    p0 = pulses[2];
    repeat (5) cycle();
    n_cmp++;
    if (pulses[2] - p0 > 1) begin
      n_err++;
      $display("FAIL mid_full got %0d pulses want <=1", pulses[2] - p0);
    end
    FULL = 4'h0;
    wait_out(30);
    repeat (2) cycle();
    n_cmp++;
    if (obs_q[2].size() != exp_q[2].size()) begin
      n_err++;
      $display("FAIL mid_cnt got %0d want %0d",
               obs_q[2].size(), exp_q[2].size());
    end
    while (obs_q[2].size() > 0 && exp_q[2].size() > 0) begin
      o = obs_q[2].pop_front();
      e = exp_q[2].pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_rec got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_post_last_stall();
    bit ok;
    apply_reset();
    pulse_start();
    send(3, rec(400), 1'b1, 2, ok);
    send(3, rec(401), 1'b0, 3, ok);
    n_cmp++;
    if (ok !== 1'b0) begin
      n_err++;
      $display("FAIL stall_after_last got %b want 0", ok);
    end
    for (int w = 0; w < 3; w++) begin
      send(w, rec(410 + w), 1'b1, 2, ok);
      n_cmp++;
      if (ok !== 1'b1) begin
        n_err++;
        $display("FAIL stall_other way%0d got %b want 1", w, ok);
      end
    end
    wait_out(30);
    repeat (3) cycle();
    n_cmp++;
    if (DONE !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done got %b want 1", DONE);
    end
    send(3, rec(402), 1'b0, 0, ok);
    n_cmp++;
    if (ok !== 1'b0) begin
      n_err++;
      $display("FAIL stall_fin got %b want 0", ok);
    end
    pulse_start();
    send(3, rec(403), 1'b0, 2, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL stall_restart got %b want 1", ok);
    end
  endtask

  task automatic test_parallel();
    bit ok;
    bit saw;
    logic [63:0] o, e;
    apply_reset();
    FULL = 4'hF;
    pulse_start();
    for (int w = 0; w < 4; w++) send(w, rec(500 + w), 1'b0, 2, ok);
    FULL = 4'h0;
    saw = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      if (DINEN == 4'hF) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b1) begin
      n_err++;
      $display("FAIL par_all got %b want 1", saw);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_q[i].size() != exp_q[i].size()) begin
        n_err++;
        $display("FAIL par_cnt lane%0d got %0d want %0d",
                 i, obs_q[i].size(), exp_q[i].size());
      end
      while (obs_q[i].size() > 0 && exp_q[i].size() > 0) begin
        o = obs_q[i].pop_front();
        e = exp_q[i].pop_front();
        n_cmp++;
        if (o !== e) begin
          n_err++;
          $display("FAIL par_rec lane%0d got %h want %h", i, o, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_batch();
    bit ok;
    int p0;
    apply_reset();
    FULL = 4'hF;
    pulse_start();
    for (int k = 0; k < 4; k++) send(0, rec(600 + k), 1'b0, 2, ok);
    for (int k = 0; k < 2; k++) send(1, rec(610 + k), 1'b0, 2, ok);
    FULL = 4'h0;
    cycle();
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (DINEN !== 4'h0 || DIN !== 256'h0) begin
      n_err++;
      $display("FAIL rmid_lanes got en=%h din=%h want 0", DINEN, DIN);
    end
    n_cmp++;
    if (DONE !== 1'b0 || sif.S_READY !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_ctl got done=%b rdy=%b want 0 0",
               DONE, sif.S_READY);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    clear_sb();
    p0 = pulses[0] + pulses[1] + pulses[2] + pulses[3];
    repeat (6) cycle();
    n_cmp++;
    if (pulses[0] + pulses[1] + pulses[2] + pulses[3] != p0) begin
      n_err++;
      $display("FAIL rmid_quiet got %0d pulses want 0",
               pulses[0] + pulses[1] + pulses[2] + pulses[3] - p0);
    end
    n_cmp++;
    if (DONE !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_done got %b want 0", DONE);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    sif.S_DIN = '0;
    sif.S_WAY = '0;
    sif.S_LAST = 1'b0;
    sif.S_VALID = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_midstream_full();
    test_post_last_stall();
    test_parallel();
    test_reset_mid_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
